// File: rtl/muldiv_seq_if.sv
// rtl/muldiv_seq_if.sv - decoder-to-muldiv request/result bundle
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             flush;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             busy;
  logic             done;
  logic             stall;
  logic [WIDTH-1:0] result;

  modport master (
    output start, flush, funct3, src_a, src_b,
    input  busy, done, stall, result
  );

  modport slave (
    input  start, flush, funct3, src_a, src_b,
    output busy, done, stall, result
  );
endinterface

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - multi-cycle RV32M multiply/divide sequencer
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input logic          clk,
  input logic          reset_n,
  muldiv_seq_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;   // {hi, lo} for mul, {rem, quot} for div
  logic [WIDTH-1:0]   m_q, m_d;         // |multiplicand| or |divisor|
  logic [WIDTH-1:0]   result_q, result_d;
  logic [2:0]         op_q, op_d;
  logic               neg_q, neg_d;     // sign of the value this op returns

  logic             is_div, a_sgn, b_sgn, a_neg, b_neg, div_zero, div_ovf;
  logic [WIDTH-1:0] a_mag, b_mag;

  // Decode the incoming op: operand signedness, magnitudes and divide special cases
  always_comb begin
    is_div   = bus.funct3[2];
    a_sgn    = is_div ? ~bus.funct3[0] : (bus.funct3[1:0] != 2'b11);
    b_sgn    = is_div ? ~bus.funct3[0] : ~bus.funct3[1];
    a_neg    = a_sgn & bus.src_a[WIDTH-1];
    b_neg    = b_sgn & bus.src_b[WIDTH-1];
    a_mag    = a_neg ? -bus.src_a : bus.src_a;
    b_mag    = b_neg ? -bus.src_b : bus.src_b;
    div_zero = is_div && (bus.src_b == '0);
    div_ovf  = is_div && ~bus.funct3[0] && (bus.src_a == MIN_NEG) && (bus.src_b == '1);
  end

  logic [WIDTH:0]     mul_sum, div_rem_sh, div_diff;
  logic [2*WIDTH-1:0] mul_step, div_step, mul_full;
  logic [WIDTH-1:0]   div_sel, fix_val;

  // One shift-add / restoring-divide step, plus the final sign fix and half select
  always_comb begin
    mul_sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, m_q} : '0);
    mul_step   = {mul_sum, prod_q[WIDTH-1:1]};
    div_rem_sh = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    div_diff   = div_rem_sh - {1'b0, m_q};
    // a clear borrow bit means the shifted remainder covered the divisor
    if (!div_diff[WIDTH]) begin
      div_step = {div_diff[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
    end else begin
      div_step = {div_rem_sh[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b0};
    end
    mul_full = neg_q ? -prod_q : prod_q;
    div_sel  = op_q[1] ? prod_q[2*WIDTH-1:WIDTH] : prod_q[WIDTH-1:0];
    if (op_q[2]) begin
      fix_val = neg_q ? -div_sel : div_sel;
    end else begin
      fix_val = (op_q[1:0] == 2'b00) ? mul_full[WIDTH-1:0] : mul_full[2*WIDTH-1:WIDTH];
    end
  end

  // Sequencer next-state and datapath register updates
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
    m_d      = m_q;
    result_d = result_q;
    op_d     = op_q;
    neg_d    = neg_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.flush) begin
          op_d  = bus.funct3;
          neg_d = (is_div && bus.funct3[1]) ? a_neg : (a_neg ^ b_neg);
          if (div_zero) begin
            result_d = bus.funct3[1] ? bus.src_a : '1;
            state_d  = S_DONE;
          end else if (div_ovf) begin
            result_d = bus.funct3[1] ? '0 : MIN_NEG;
            state_d  = S_DONE;
          end else begin
            m_d     = is_div ? b_mag : a_mag;
            prod_d  = {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
            cnt_d   = '0;
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        prod_d = op_q[2] ? div_step : mul_step;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = fix_val;
        state_d  = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // a cancelled op never reaches the result register
    if (bus.flush && (state_q != S_IDLE)) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      prod_q   <= '0;
      m_q      <= '0;
      result_q <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
      m_q      <= m_d;
      result_q <= result_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
    end
  end

  assign bus.busy   = (state_q == S_CALC) || (state_q == S_FIX);
  assign bus.done   = (state_q == S_DONE);
  assign bus.stall  = (bus.start && (state_q == S_IDLE) && !bus.flush) || bus.busy;
  assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - self-checking bench for muldiv_seq
module tb_muldiv_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  muldiv_seq_if #(.WIDTH(W)) bus_if ();

  muldiv_seq #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // expected-timeline state for the op currently in flight
  bit          chk_en = 1'b0;
  bit          op_valid = 1'b0;
  bit          op_special = 1'b0;
  int          op_s = 0;
  int          op_done_at = 0;
  int          kill_cyc = 1 << 30;
  int          rst_at = -10;
  logic [31:0] op_exp = '0;
  logic [31:0] ref_result = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // RV32M reference results from plain 64-bit arithmetic
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, sp;
    logic [63:0] ua, ub, up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    up = '0;
    case (f)
      3'd0: begin sp = sa * sb; up = sp; return up[31:0]; end
      3'd1: begin sp = sa * sb; up = sp; return up[63:32]; end
      3'd2: begin sp = sa * $signed(ub); up = sp; return up[63:32]; end
      3'd3: begin up = ua * ub; return up[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        sp = sa / sb; up = sp; return up[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        sp = sa % sb; up = sp; return up[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Per-cycle compare of all outputs against the expected op timeline
  always @(negedge clk) begin
    logic e_busy, e_done, e_stall;
    if (chk_en) begin
      if (op_valid && cyc == op_done_at && cyc <= kill_cyc) ref_result = op_exp;
      if (cyc == rst_at + 1) ref_result = '0;
      e_busy  = op_valid && !op_special && cyc >= op_s + 1 && cyc <= op_s + W + 1 && cyc <= kill_cyc;
      e_done  = op_valid && cyc == op_done_at && cyc <= kill_cyc;
      e_stall = op_valid && cyc >= op_s && cyc < op_done_at && cyc <= kill_cyc;
      chk("busy",   {31'b0, bus_if.busy},  {31'b0, e_busy});
      chk("done",   {31'b0, bus_if.done},  {31'b0, e_done});
      chk("stall",  {31'b0, bus_if.stall}, {31'b0, e_stall});
      chk("result", bus_if.result, ref_result);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    bus_if.start  = 1'b1;
    bus_if.funct3 = f;
    bus_if.src_a  = a;
    bus_if.src_b  = b;
    op_s       = cyc;
    op_exp     = model(f, a, b);
    op_special = f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    op_done_at = op_special ? cyc + 1 : cyc + W + 2;
    kill_cyc   = 1 << 30;
    op_valid   = 1'b1;
    tick();
    bus_if.start  = 1'b0;
    bus_if.funct3 = ~f;
    bus_if.src_a  = $urandom;
    bus_if.src_b  = $urandom;
  endtask

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] lit);
    start_op(f, a, b);
    for (int i = 0; i < 100 && cyc < op_done_at; i++) tick();
    @(negedge clk);
    chk({name, "_done"}, {31'b0, bus_if.done}, 32'd1);
    chk(name, bus_if.result, lit);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bus_if.start  = 1'b0;
    bus_if.flush  = 1'b0;
    bus_if.funct3 = 3'd0;
    bus_if.src_a  = '0;
    bus_if.src_b  = '0;
    tick();
    tick();
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_busy",   {31'b0, bus_if.busy},  32'd0);
    chk("rst_done",   {31'b0, bus_if.done},  32'd0);
    chk("rst_stall",  {31'b0, bus_if.stall}, 32'd0);
    chk("rst_result", bus_if.result, 32'd0);
    chk_en = 1'b1;
    tick();

    // reset asserted for two cycles in the middle of CALC
    start_op(3'd0, 32'd3, 32'd5);
    repeat (7) tick();
    reset_n  = 1'b0;
    kill_cyc = cyc;
    rst_at   = cyc;
    tick();
    tick();
    reset_n = 1'b1;
    chk("midrst_result", bus_if.result, 32'd0);
    tick();
    run_op("mul_after_rst", 3'd0, 32'd3, 32'd5, 32'd15);

    run_op("mul_neg",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
    run_op("mulh_min",   3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
    run_op("mulhu_min",  3'd3, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000);
    run_op("mulhsu",     3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF);
    run_op("mulhu_max",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("div_neg",    3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
    run_op("rem_neg",    3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
    run_op("div_negb",   3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD);
    run_op("rem_negb",   3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1);
    run_op("divu",       3'd5, 32'd100,        32'd7,         32'd14);
    run_op("remu",       3'd7, 32'd100,        32'd7,         32'd2);
    run_op("divu_z",     3'd5, 32'h1234,       32'd0,         32'hFFFF_FFFF);
    run_op("remu_z",     3'd7, 32'h1234,       32'd0,         32'h1234);
    run_op("div_z",      3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF);
    run_op("div_ovf",    3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
    run_op("rem_ovf",    3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0);

    // flush during cycle 10 of a MUL: no done, result keeps the previous value
    start_op(3'd0, 32'd9, 32'd9);
    while (cyc < op_s + 10) tick();
    bus_if.flush = 1'b1;
    kill_cyc = cyc;
    tick();
    bus_if.flush = 1'b0;
    @(negedge clk);
    chk("flush_busy",   {31'b0, bus_if.busy}, 32'd0);
    chk("flush_result", bus_if.result, 32'd0);
    repeat (30) tick();

    // start and flush together in IDLE: nothing launches
    bus_if.start  = 1'b1;
    bus_if.flush  = 1'b1;
    bus_if.funct3 = 3'd0;
    bus_if.src_a  = 32'd4;
    bus_if.src_b  = 32'd4;
    tick();
    bus_if.start = 1'b0;
    bus_if.flush = 1'b0;
    @(negedge clk);
    chk("sf_busy", {31'b0, bus_if.busy}, 32'd0);
    tick();

    // a second start during CALC is ignored
    start_op(3'd0, 32'd6, 32'd7);
    repeat (4) tick();
    bus_if.start  = 1'b1;
    bus_if.funct3 = 3'd5;
    bus_if.src_a  = 32'd1;
    bus_if.src_b  = 32'd0;
    tick();
    bus_if.start = 1'b0;
    for (int i = 0; i < 100 && cyc < op_done_at; i++) tick();
    @(negedge clk);
    chk("ignored_start", bus_if.result, 32'd42);
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
